// File: rtl/frame_addr_gen.sv
// rtl/frame_addr_gen.sv - frame-buffer write-address generator with decimation and end-of-frame saturation
module frame_addr_gen #(
   parameter int H_ACTIVE         = 640,
   parameter int V_ACTIVE         = 480,
   parameter int ADDR_W           = 19,
   parameter int BASE_ADDR        = 0,
   parameter int VSYNC_ACTIVE_LOW = 1
) (
   input  logic              CLK25,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              enable,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] address,
   output logic              addr_valid,
   output logic              line_end,
   output logic              frame_done,
   output logic              overflow
);

   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_1 = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] LAST_2 = ADDR_W'(H_ACTIVE * V_ACTIVE / 4 - 1);
   localparam logic [ADDR_W-1:0] LAST_4 = ADDR_W'(H_ACTIVE * V_ACTIVE / 16 - 1);
   localparam logic [XW-1:0]     X_LAST = XW'(H_ACTIVE - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t            r_state;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [ADDR_W-1:0] r_wr_cnt;
   logic [1:0]        r_mode_q;

   logic              w_blank;
   logic [1:0]        w_mask;
   logic [ADDR_W-1:0] w_last;
   logic              w_keep;
   logic              w_x_end;
   logic              w_last_cnt;

   // Decimation by 2 or 4 keeps pixels whose low coordinate bits are zero.
   always_comb begin
      w_blank = (VSYNC_ACTIVE_LOW != 0) ? !vsync : vsync;
      w_mask  = 2'b00;
      w_last  = LAST_1;
      case (r_mode_q)
         2'd1: begin
            w_mask = 2'b01;
            w_last = LAST_2;
         end
         2'd2: begin
            w_mask = 2'b11;
            w_last = LAST_4;
         end
         default: begin
            w_mask = 2'b00;
            w_last = LAST_1;
         end
      endcase
      w_keep     = ((r_x[1:0] & w_mask) == 2'b00) && ((r_y[1:0] & w_mask) == 2'b00);
      w_x_end    = (r_x == X_LAST);
      w_last_cnt = (r_wr_cnt == w_last);
   end

   always_ff @(posedge CLK25 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_wr_cnt   <= '0;
         r_mode_q   <= 2'd0;
         address    <= BASE;
         addr_valid <= 1'b0;
         line_end   <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else if (w_blank) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_wr_cnt   <= '0;
         r_mode_q   <= mode;
         addr_valid <= 1'b0;
         line_end   <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         addr_valid <= 1'b0;
         line_end   <= 1'b0;
         frame_done <= 1'b0;
         if (enable) begin
            line_end <= w_x_end;
            if (w_x_end) begin
               r_x <= '0;
               r_y <= r_y + YW'(1);
            end else begin
               r_x <= r_x + XW'(1);
            end
         end
         if (r_state == S_DONE) begin
            if (enable) begin
               overflow <= 1'b1;
            end
         end else begin
            r_state <= S_ACTIVE;
            if (enable && w_keep) begin
               address    <= BASE + r_wr_cnt;
               addr_valid <= 1'b1;
               r_wr_cnt   <= r_wr_cnt + ADDR_W'(1);
               if (w_last_cnt) begin
                  r_state    <= S_DONE;
                  frame_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_addr_gen.sv
// tb/tb_frame_addr_gen.sv - self-checking bench for frame_addr_gen on a reduced 16x8 geometry
module tb_frame_addr_gen;

   localparam int H    = 16;
   localparam int V    = 8;
   localparam int AW   = 8;
   localparam int BASE = 100;

   logic          CLK25;
   logic          rst_n;
   logic          vsync;
   logic          enable;
   logic [1:0]    mode;
   logic [AW-1:0] address;
   logic          addr_valid;
   logic          line_end;
   logic          frame_done;
   logic          overflow;

   frame_addr_gen #(
      .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BASE_ADDR(BASE), .VSYNC_ACTIVE_LOW(1)
   ) dut (
      .CLK25(CLK25), .rst_n(rst_n), .vsync(vsync), .enable(enable), .mode(mode),
      .address(address), .addr_valid(addr_valid), .line_end(line_end),
      .frame_done(frame_done), .overflow(overflow)
   );

   initial CLK25 = 1'b0;
   always #5 CLK25 = ~CLK25;

   typedef struct {
      logic [AW-1:0] a;
      logic          v;
      logic          le;
      logic          fd;
      logic          ovf;
   } exp_t;

   typedef struct {
      logic [1:0] md;
      int         n;
      int         gap;
      bit         chg;
      int         wr;
      int         last;
      int         fd;
      int         le;
      int         ovf;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[8];

   int n_err = 0;
   int n_chk = 0;
   int n_wr, n_fd, n_le, first_a, last_a;

   // Reference model state
   int            m_st;
   int            m_x, m_y, m_cnt;
   logic [1:0]    m_mode;
   logic [AW-1:0] m_a;
   logic          m_v, m_le, m_fd, m_ovf;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_x = 0; m_y = 0; m_cnt = 0; m_mode = 2'd0;
      m_a = AW'(BASE); m_v = 0; m_le = 0; m_fd = 0; m_ovf = 0;
   endtask

   task automatic model(input logic vs, input logic en, input logic [1:0] md);
      int s;
      int last;
      if (!vs) begin
         m_st = 0; m_x = 0; m_y = 0; m_cnt = 0; m_ovf = 0; m_mode = md;
         m_v = 0; m_le = 0; m_fd = 0;
      end else begin
         s    = (m_mode == 2'd1) ? 2 : (m_mode == 2'd2) ? 4 : 1;
         last = H * V / (s * s) - 1;
         m_v = 0; m_le = 0; m_fd = 0;
         if (m_st == 2) begin
            if (en) m_ovf = 1;
         end else begin
            m_st = 1;
            if (en && (m_x % s == 0) && (m_y % s == 0)) begin
               m_a = AW'(BASE + m_cnt);
               m_v = 1;
               if (m_cnt == last) begin
                  m_st = 2;
                  m_fd = 1;
               end
               m_cnt++;
            end
         end
         if (en) begin
            m_le = (m_x == H - 1);
            if (m_x == H - 1) begin
               m_x = 0;
               m_y++;
            end else begin
               m_x++;
            end
         end
      end
   endtask

   task automatic step(input logic vs, input logic en, input logic [1:0] md);
      exp_t e;
      vsync  = vs;
      enable = en;
      mode   = md;
      model(vs, en, md);
      e.a = m_a; e.v = m_v; e.le = m_le; e.fd = m_fd; e.ovf = m_ovf;
      sb_q.push_back(e);
      @(posedge CLK25);
      #1;
      e = sb_q.pop_front();
      check("outputs{addr,valid,le,fd,ovf}",
            {20'd0, address, addr_valid, line_end, frame_done, overflow},
            {20'd0, e.a, e.v, e.le, e.fd, e.ovf});
      if (addr_valid) begin
         if (n_wr == 0) first_a = int'(address);
         n_wr++;
         last_a = int'(address);
      end
      if (frame_done) n_fd++;
      if (line_end) n_le++;
   endtask

   task automatic clear_stats();
      n_wr = 0; n_fd = 0; n_le = 0; first_a = -1; last_a = -1;
   endtask

   task automatic run_frame(input vec_t t, input int idx);
      logic [1:0] md_i;
      repeat (3) step(1'b0, 1'b0, t.md);
      clear_stats();
      for (int i = 0; i < t.n; i++) begin
         md_i = (t.chg && i >= 20) ? 2'd0 : t.md;
         step(1'b1, 1'b1, md_i);
         for (int g = 0; g < t.gap; g++) step(1'b1, 1'b0, md_i);
      end
      step(1'b1, 1'b0, t.md);
      check($sformatf("v%0d writes", idx), n_wr, t.wr);
      check($sformatf("v%0d first_addr", idx), first_a, BASE);
      check($sformatf("v%0d last_addr", idx), last_a, t.last);
      check($sformatf("v%0d frame_done", idx), n_fd, t.fd);
      check($sformatf("v%0d line_end", idx), n_le, t.le);
      check($sformatf("v%0d overflow", idx), {31'd0, overflow}, t.ovf);
   endtask

   initial begin
      //          md    n    gap chg  wr   last fd le ovf
      vecs[0] = '{2'd0, 128, 0, 0, 128, 227, 1, 8, 0};
      vecs[1] = '{2'd0, 138, 0, 0, 128, 227, 1, 8, 1};
      vecs[2] = '{2'd1, 128, 1, 0,  32, 131, 1, 8, 1};
      vecs[3] = '{2'd2, 128, 0, 1,   8, 107, 1, 8, 1};
      vecs[4] = '{2'd3, 128, 0, 0, 128, 227, 1, 8, 0};
      vecs[5] = '{2'd0,  50, 0, 0,  50, 149, 0, 3, 0};
      vecs[6] = '{2'd2,  76, 0, 0,   7, 106, 0, 4, 0};
      vecs[7] = '{2'd2,  77, 0, 0,   8, 107, 1, 4, 0};

      rst_n = 1'b0; vsync = 1'b0; enable = 1'b0; mode = 2'd0;
      model_reset();
      repeat (2) @(posedge CLK25);
      #1;
      check("reset address", {24'd0, address}, BASE);
      check("reset flags", {28'd0, addr_valid, line_end, frame_done, overflow}, 0);
      #3 rst_n = 1'b1;
      @(posedge CLK25);
      #1;

      for (int k = 0; k < 8; k++) run_frame(vecs[k], k);

      // mode 1: only even x / even y kept; second stored line begins on camera line 2
      repeat (3) step(1'b0, 1'b0, 2'd1);
      step(1'b1, 1'b1, 2'd1);
      check("m1 e0", {23'd0, address, addr_valid}, {23'd0, 8'd100, 1'b1});
      step(1'b1, 1'b1, 2'd1);
      check("m1 e1", {23'd0, address, addr_valid}, {23'd0, 8'd100, 1'b0});
      step(1'b1, 1'b1, 2'd1);
      check("m1 e2", {23'd0, address, addr_valid}, {23'd0, 8'd101, 1'b1});
      for (int i = 3; i < 32; i++) step(1'b1, 1'b1, 2'd1);
      check("m1 line1 last", {23'd0, address, addr_valid}, {23'd0, 8'd107, 1'b0});
      step(1'b1, 1'b1, 2'd1);
      check("m1 line2 start", {23'd0, address, addr_valid}, {23'd0, 8'd108, 1'b1});

      // blanking coincident with enable drops the pixel
      step(1'b0, 1'b1, 2'd0);
      check("blank+enable", {31'd0, addr_valid}, 0);
      clear_stats();
      step(1'b1, 1'b1, 2'd0);
      step(1'b1, 1'b1, 2'd0);
      check("after blank first", first_a, BASE);

      // asynchronous reset between clock edges mid-frame
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'd0);
      enable = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async rst address", {24'd0, address}, BASE);
      check("async rst flags", {28'd0, addr_valid, line_end, frame_done, overflow}, 0);
      model_reset();
      #2 rst_n = 1'b1;
      clear_stats();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0);
      check("post rst first", first_a, BASE);
      check("post rst last", last_a, BASE + 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
